// File: rtl/lag_packetizer.sv
// lag_packetizer
// ---------------------------------------------------------------------------
// Takes each set of NUM_XCORRS lag indices from the peak-finding stage,
// buffers the sets in a small FIFO and sends every set as a byte packet on a
// valid/ready byte stream for the UART/host-link stage.
//
// Packet: HEADER_BYTE, lag 0 .. lag NUM_XCORRS-1, then an optional checksum.
// Lag byte = index - MAX_LAGS (8-bit two's complement). An index above
// 2*MAX_LAGS is sent as 8'h80.
//
// Optional feature, macro LAG_PKT_CHECKSUM_EN: when it is defined, a final
// byte holds the XOR of the header and all lag bytes (CHK state present).
//
// Handshake: a byte transfers on a rising clk edge where byteOutValid and
// byteOutReady are both high. While byteOutValid is high, byteOut and
// byteOutValid hold until that transfer. byteOutReady is ignored while
// byteOutValid is low.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   dataIn       in   lag indices, index k at [k*BITS_PER_XCORR +: BITS_PER_XCORR]
//   dataInValid  in   single-cycle pulse qualifying dataIn
//   byteOut      out  packet byte (registered)
//   byteOutValid out  byteOut is valid (registered)
//   byteOutReady in   consumer accepts byteOut
//   dropCount    out  saturating count of sets dropped on overflow
//   busy         out  FIFO non-empty or packet in progress
//   state_dbg    out  current FSM state (debug)
module lag_packetizer #(
  parameter int         NUM_XCORRS     = 6,
  parameter int         BITS_PER_XCORR = 6,
  parameter int         MAX_LAGS       = 11,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_XCORRS*BITS_PER_XCORR-1:0] dataIn,
  input  logic                                 dataInValid,
  output logic [7:0]                           byteOut,
  output logic                                 byteOutValid,
  input  logic                                 byteOutReady,
  output logic [7:0]                           dropCount,
  output logic                                 busy,
  output logic [1:0]                           state_dbg
);

  localparam int SET_W  = NUM_XCORRS * BITS_PER_XCORR;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int LCNT_W = (NUM_XCORRS > 1) ? $clog2(NUM_XCORRS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    LAG  = 2'd2
`ifdef LAG_PKT_CHECKSUM_EN
    , CHK = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d, lcnt_inc;
  logic [7:0]          byte_d;
  logic                valid_d;

  logic [SET_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count, fifo_count_d;
  logic                fifo_empty, fifo_full;
  logic                push, pop, drop;

  logic [SET_W-1:0]    head;
  logic [7:0]          conv [NUM_XCORRS];
  logic [7:0]          lag_q [NUM_XCORRS];
`ifdef LAG_PKT_CHECKSUM_EN
  logic [7:0]          conv_chk, chk_q;
`endif

  function automatic logic [7:0] to_lag(input logic [BITS_PER_XCORR-1:0] idx);
    int unsigned v;
    v = 32'(idx);
    if (v > 32'(2 * MAX_LAGS)) return 8'h80;
    return 8'(v - 32'(MAX_LAGS));
  endfunction

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];
  assign lcnt_inc   = lcnt_q + LCNT_W'(1);
  assign state_dbg  = state_q;

  // A full FIFO still accepts a push when the FSM pops in the same cycle.
  // pop is derived from the registered count, so a push into an empty FIFO
  // is never popped in the cycle it arrives.
  assign push = dataInValid && (!fifo_full || pop);
  assign drop = dataInValid && !push;

  always_comb begin
    for (int k = 0; k < NUM_XCORRS; k++) begin
      conv[k] = to_lag(head[k*BITS_PER_XCORR +: BITS_PER_XCORR]);
    end
  end

`ifdef LAG_PKT_CHECKSUM_EN
  always_comb begin
    conv_chk = HEADER_BYTE;
    for (int k = 0; k < NUM_XCORRS; k++) begin
      conv_chk = conv_chk ^ conv[k];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    byte_d  = byteOut;
    valid_d = byteOutValid;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = HDR;
          byte_d  = HEADER_BYTE;
          valid_d = 1'b1;
        end
      end
      HDR: begin
        if (byteOutReady) begin
          state_d = LAG;
          lcnt_d  = '0;
          byte_d  = lag_q[0];
        end
      end
      LAG: begin
        if (byteOutReady) begin
          if (lcnt_q == LCNT_W'(NUM_XCORRS - 1)) begin
`ifdef LAG_PKT_CHECKSUM_EN
            state_d = CHK;
            byte_d  = chk_q;
`else
            state_d = IDLE;
            byte_d  = 8'h00;
            valid_d = 1'b0;
`endif
          end else begin
            lcnt_d = lcnt_inc;
            byte_d = lag_q[lcnt_inc];
          end
        end
      end
`ifdef LAG_PKT_CHECKSUM_EN
      CHK: begin
        if (byteOutReady) begin
          state_d = IDLE;
          byte_d  = 8'h00;
          valid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        byte_d  = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    fifo_count_d = fifo_count;
    if (push && !pop)      fifo_count_d = fifo_count + CNT_W'(1);
    else if (pop && !push) fifo_count_d = fifo_count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lcnt_q       <= '0;
      byteOut      <= 8'h00;
      byteOutValid <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      dropCount    <= 8'h00;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      byteOut      <= byte_d;
      byteOutValid <= valid_d;
      fifo_count   <= fifo_count_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop && (dropCount != 8'hFF)) dropCount <= dropCount + 8'd1;
      busy         <= (fifo_count_d != '0) || (state_d != IDLE);
    end
  end

  // Storage without reset: FIFO contents and the shadow copy of the packet
  // being sent. The shadow lets the FIFO keep accepting sets mid-packet.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dataIn;
    if (pop) begin
      for (int k = 0; k < NUM_XCORRS; k++) lag_q[k] <= conv[k];
`ifdef LAG_PKT_CHECKSUM_EN
      chk_q <= conv_chk;
`endif
    end
  end

endmodule

// File: tb/tb_lag_packetizer.sv
module tb_lag_packetizer;

`ifdef LAG_PKT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [35:0] dataIn = '0;
  logic        dataInValid = 1'b0;
  logic [7:0]  byteOut;
  logic        byteOutValid;
  logic        byteOutReady = 1'b0;
  logic [7:0]  dropCount;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  localparam logic [35:0] SET_ALL11 = {6{6'd11}};
  localparam logic [35:0] SET_RAMP  = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
  localparam logic [47:0] LAG_RAMP  = {8'hFA, 8'hF9, 8'hF8, 8'hF7, 8'hF6, 8'hF5};

  lag_packetizer dut (
    .clk          (clk),
    .rst          (rst),
    .dataIn       (dataIn),
    .dataInValid  (dataInValid),
    .byteOut      (byteOut),
    .byteOutValid (byteOutValid),
    .byteOutReady (byteOutReady),
    .dropCount    (dropCount),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: every transferred byte is popped and compared;
  // a stalled byte must be unchanged on the following cycle
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(byteOutValid), 32'd1);
        check("hold_byte", 32'(byteOut), 32'(prev_byte));
      end
      if (byteOutValid && byteOutReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", byteOut);
        end else begin
          check("stream_byte", 32'(byteOut), 32'(exp_q.pop_front()));
        end
      end
      prev_stall <= byteOutValid && !byteOutReady;
      prev_byte  <= byteOut;
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [35:0] d);
    dataIn      = d;
    dataInValid = 1'b1;
    tick();
    dataInValid = 1'b0;
  endtask

  task automatic exp_pkt(input logic [47:0] lags, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 6; k++) exp_q.push_back(lags[k*8 +: 8]);
    if (CHK_EN) exp_q.push_back(chk);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!byteOutValid && n < budget) begin
      tick();
      n++;
    end
    if (!byteOutValid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: got valid=0 expected valid=1");
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got pending=%0d busy=%0b expected 0 0",
               exp_q.size(), busy);
    end
  endtask

  initial begin
    logic [7:0] lb;

    tick(3);
    check("rst_byte", 32'(byteOut), 32'h00);
    check("rst_valid", 32'(byteOutValid), 32'd0);
    check("rst_drop", 32'(dropCount), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b1;
    tick(2);

    // single set of centre lags, header two cycles after the pulse
    byteOutReady = 1'b1;
    exp_pkt(48'h0, 8'hA5);
    pulse(SET_ALL11);
    check("busy_after_push", 32'(busy), 32'd1);
    check("lat_n1_valid", 32'(byteOutValid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(byteOutValid), 32'd1);
    check("lat_n2_hdr", 32'(byteOut), 32'hA5);
    wait_idle(50);

    // back-to-back sets: ramp, upper bound on lane 0, invalid index on lane 1
    exp_pkt(LAG_RAMP, 8'hAA);
    pulse(SET_RAMP);
    exp_pkt(48'h0000_0000_000B, 8'hAE);
    pulse({{5{6'd11}}, 6'd22});
    exp_pkt(48'h0000_0000_8000, 8'h25);
    pulse({{4{6'd11}}, 6'd40, 6'd11});
    wait_idle(100);
    check("no_drops", 32'(dropCount), 32'd0);

    // backpressure while lag 2 is presented
    byteOutReady = 1'b0;
    exp_pkt(LAG_RAMP, 8'hAA);
    pulse(SET_RAMP);
    wait_valid(20);
    byteOutReady = 1'b1;
    tick(3);
    byteOutReady = 1'b0;
    repeat (5) begin
      check("bp_byte", 32'(byteOut), 32'hF7);
      check("bp_valid", 32'(byteOutValid), 32'd1);
      tick();
    end
    byteOutReady = 1'b1;
    wait_idle(50);

    // overflow: 7 sets, shadow + 4 FIFO entries accepted, 2 dropped
    byteOutReady = 1'b0;
    for (int j = 0; j < 7; j++) begin
      lb = 8'(j) - 8'd11;
      if (j < 5) exp_pkt({6{lb}}, 8'hA5);
      pulse({6{6'(j)}});
      tick();
    end
    check("ovf_drop", 32'(dropCount), 32'd2);
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_state_hdr", 32'(state_dbg), 32'd1);
    byteOutReady = 1'b1;
    wait_idle(100);
    check("ovf_busy_end", 32'(busy), 32'd0);

    // saturation of dropCount
    byteOutReady = 1'b0;
    for (int j = 0; j < 5; j++) begin
      exp_pkt(48'h0, 8'hA5);
      pulse(SET_ALL11);
    end
    dataIn      = SET_ALL11;
    dataInValid = 1'b1;
    tick(100);
    check("sat_mid", 32'(dropCount), 32'd102);
    tick(200);
    dataInValid = 1'b0;
    check("sat_255", 32'(dropCount), 32'd255);
    pulse(SET_ALL11);
    pulse(SET_ALL11);
    tick();
    check("sat_hold", 32'(dropCount), 32'd255);
    byteOutReady = 1'b1;
    wait_idle(200);

    // reset while lag 3 is presented
    byteOutReady = 1'b0;
    exp_pkt(LAG_RAMP, 8'hAA);
    pulse(SET_RAMP);
    wait_valid(20);
    byteOutReady = 1'b1;
    tick(4);
    byteOutReady = 1'b0;
    check("pre_rst_lag3", 32'(byteOut), 32'hF8);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(byteOutValid), 32'd0);
    check("mid_rst_drop", 32'(dropCount), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_byte", 32'(byteOut), 32'h00);
    tick(2);
    rst = 1'b1;
    tick();
    byteOutReady = 1'b1;
    exp_pkt(LAG_RAMP, 8'hAA);
    pulse(SET_RAMP);
    tick();
    check("post_rst_valid", 32'(byteOutValid), 32'd1);
    check("post_rst_hdr", 32'(byteOut), 32'hA5);
    wait_idle(50);
    check("post_rst_drop", 32'(dropCount), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
